// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-functional-unit result FIFOs feeding a round-robin
// arbiter. Register results go to WB_PORTS registered writeback ports, memory
// ops go to a single held-until-accepted memory port, and null ops are dropped.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous clear of FIFOs, outputs and rr pointer
//   fu_valid/fu_ready     per-channel handshake (NUM_FU bits)
//   fu_result/dest/rob    flattened per-channel payload, channel i at [i*W +: W]
//   fu_regwrite/memread/memwrite/memsize  per-channel control bits
//   wb_valid/dest/value/rob               registered writeback ports
//   mem_valid/mem_ready                   memory-op handshake
//   mem_addr/dest/rob/write/size          memory-op payload
//
// Build option: define WB_BYPASS_EN to let an entry arriving at an empty
// channel arbitrate in its arrival cycle (one-edge latency). Without it an
// entry is registered in its FIFO first (two-edge latency) and no fu_* input
// reaches the grant logic combinationally.

module writeback_arbiter_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module writeback_arbiter #(
  parameter int NUM_FU   = 3,
  parameter int WB_PORTS = 2,
  parameter int DATA_W   = 32,
  parameter int PREG_W   = 6,
  parameter int ROB_W    = 6,
  parameter int CH_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic [NUM_FU*DATA_W-1:0]     fu_result,
  input  logic [NUM_FU*PREG_W-1:0]     fu_dest,
  input  logic [NUM_FU*ROB_W-1:0]      fu_rob,
  input  logic [NUM_FU-1:0]            fu_regwrite,
  input  logic [NUM_FU-1:0]            fu_memread,
  input  logic [NUM_FU-1:0]            fu_memwrite,
  input  logic [NUM_FU-1:0]            fu_memsize,
  output logic [WB_PORTS-1:0]          wb_valid,
  output logic [WB_PORTS*PREG_W-1:0]   wb_dest,
  output logic [WB_PORTS*DATA_W-1:0]   wb_value,
  output logic [WB_PORTS*ROB_W-1:0]    wb_rob,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [DATA_W-1:0]            mem_addr,
  output logic [PREG_W-1:0]            mem_dest,
  output logic [ROB_W-1:0]             mem_rob,
  output logic                         mem_write,
  output logic                         mem_size
);
  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [PREG_W-1:0] dest;
    logic [ROB_W-1:0]  rob;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memsize;
  } ent_t;
  localparam int EW = $bits(ent_t);

  ent_t [NUM_FU-1:0]   in_ent, head, cand;
  logic [NUM_FU-1:0]   empty, full, push, pop, cand_vld, cand_byp, consume;
  ent_t [WB_PORTS-1:0] port_ent;
  logic [WB_PORTS-1:0] port_gnt;
  ent_t                mem_ent;
  logic                mem_gnt, mem_free;
  logic [RR_W-1:0]     rr_ptr, nxt_rr;
  logic                unused_bits;

  // no credit for a same-cycle pop: ready depends on registered occupancy only
  assign fu_ready = ~full;
  assign mem_free = !mem_valid || mem_ready;
  // control bits are not needed once an entry has been routed
  assign unused_bits = ^{port_ent, mem_ent};

  for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
    assign in_ent[i] = '{result:   fu_result[i*DATA_W +: DATA_W],
                         dest:     fu_dest[i*PREG_W +: PREG_W],
                         rob:      fu_rob[i*ROB_W +: ROB_W],
                         regwrite: fu_regwrite[i],
                         memread:  fu_memread[i],
                         memwrite: fu_memwrite[i],
                         memsize:  fu_memsize[i]};

`ifdef WB_BYPASS_EN
    // an arrival at an empty channel competes directly; it is only written
    // into the FIFO if it loses arbitration
    assign cand_byp[i] = empty[i] && fu_valid[i];
    assign cand[i]     = empty[i] ? in_ent[i] : head[i];
    assign cand_vld[i] = !empty[i] || fu_valid[i];
    assign push[i]     = fu_valid[i] && !full[i] && !(cand_byp[i] && consume[i]);
    assign pop[i]      = !empty[i] && consume[i];
`else
    assign cand_byp[i] = 1'b0;
    assign cand[i]     = head[i];
    assign cand_vld[i] = !empty[i];
    assign push[i]     = fu_valid[i] && !full[i];
    assign pop[i]      = consume[i];
`endif

    writeback_arbiter_fifo #(.W(EW), .DEPTH(CH_DEPTH)) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .flush  (flush),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    (in_ent[i]),
      .head   (head[i]),
      .empty  (empty[i]),
      .full   (full[i])
    );
  end

  // Scan in round-robin order from rr_ptr. Pass 0 takes queued heads, pass 1
  // takes bypass arrivals, so queued work always outranks new arrivals.
  always_comb begin
    int n;
    int r;
    consume  = '0;
    port_gnt = '0;
    port_ent = '0;
    mem_gnt  = 1'b0;
    mem_ent  = '0;
    nxt_rr   = rr_ptr;
    n        = 0;
    r        = 0;
    for (int i = 0; i < NUM_FU; i++)
      if (cand_vld[i] && !cand[i].regwrite && !cand[i].memread && !cand[i].memwrite)
        consume[i] = 1'b1;
    for (int pass = 0; pass < 2; pass++)
      for (int k = 0; k < NUM_FU; k++)
        for (int i = 0; i < NUM_FU; i++) begin
          r = i - int'(rr_ptr);
          if (r < 0) r = r + NUM_FU;
          if (r == k && cand_vld[i] && (cand_byp[i] == (pass == 1))) begin
            if (cand[i].memread || cand[i].memwrite) begin
              if (!mem_gnt && mem_free) begin
                mem_gnt    = 1'b1;
                mem_ent    = cand[i];
                consume[i] = 1'b1;
                nxt_rr     = RR_W'((i + 1) % NUM_FU);
              end
            end else if (cand[i].regwrite && n < WB_PORTS) begin
              for (int p = 0; p < WB_PORTS; p++)
                if (p == n) begin
                  port_gnt[p] = 1'b1;
                  port_ent[p] = cand[i];
                end
              n          = n + 1;
              consume[i] = 1'b1;
              nxt_rr     = RR_W'((i + 1) % NUM_FU);
            end
          end
        end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      wb_valid  <= '0;
      wb_dest   <= '0;
      wb_value  <= '0;
      wb_rob    <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_dest  <= '0;
      mem_rob   <= '0;
      mem_write <= 1'b0;
      mem_size  <= 1'b0;
    end else if (flush) begin
      rr_ptr    <= '0;
      wb_valid  <= '0;
      mem_valid <= 1'b0;
    end else begin
      rr_ptr   <= nxt_rr;
      wb_valid <= port_gnt;
      for (int p = 0; p < WB_PORTS; p++)
        if (port_gnt[p]) begin
          wb_dest[p*PREG_W +: PREG_W]  <= port_ent[p].dest;
          wb_value[p*DATA_W +: DATA_W] <= port_ent[p].result;
          wb_rob[p*ROB_W +: ROB_W]     <= port_ent[p].rob;
        end
      // payload only reloads on a grant, and grants need mem_free, so an
      // unaccepted op is held
      if (mem_gnt) begin
        mem_valid <= 1'b1;
        mem_addr  <= mem_ent.result;
        mem_dest  <= mem_ent.dest;
        mem_rob   <= mem_ent.rob;
        mem_write <= mem_ent.memwrite;
        mem_size  <= mem_ent.memsize;
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end
endmodule
